// File: rtl/lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_char_ctrl
//
// HD44780-class character LCD controller, 8-bit write-only mode. After reset
// it waits for the panel to power up, sends the init commands (function set,
// display on, entry mode, clear), waits out the clear, and then refreshes the
// panel from a COLS x LINES character frame buffer, one line at a time
// (set-address command followed by COLS data bytes).
//
// Every byte goes out in a fixed slot: lcd_data/lcd_rs are loaded on the first
// cycle of the slot and held; lcd_en is high for EN_HIGH_CYC cycles and then
// low for EN_LOW_CYC cycles.
//
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   wr_en        - single-cycle frame-buffer write strobe
//   wr_addr      - buffer index = line*COLS + col (out-of-range ignored)
//   wr_char      - ASCII character to store
//   refresh_en   - 1 = keep refreshing, 0 = stop after the current frame
//   lcd_rs       - 0 = command byte, 1 = data byte
//   lcd_rw       - always 0 (write-only)
//   lcd_en       - LCD enable strobe
//   lcd_data     - LCD data bus
//   init_done    - high from the end of the init sequence until reset
//   frame_done   - one-cycle pulse on the last cycle of each frame
// -----------------------------------------------------------------------------
module lcd_char_ctrl #(
    parameter int COLS         = 16,
    parameter int LINES        = 2,
    parameter int EN_HIGH_CYC  = 990,
    parameter int EN_LOW_CYC   = 989,
    parameter int PWR_WAIT_CYC = 750000,
    parameter int CLR_WAIT_CYC = 82000,
    localparam int N           = COLS * LINES,
    localparam int AW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          refresh_en,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_data,
    output logic          init_done,
    output logic          frame_done
);

    localparam int SLOT  = EN_HIGH_CYC + EN_LOW_CYC;
    localparam int MAX_A = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAX_C = (MAX_A > SLOT) ? MAX_A : SLOT;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [7:0] FUNC_SET = (LINES >= 2) ? 8'h38 : 8'h30;
    localparam logic [7:0] SPACE    = 8'h20;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_CLR_WAIT,
        S_SET_ADDR,
        S_WRITE_CHAR,
        S_IDLE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     step, step_n;
    logic [LW-1:0]  line, line_n;
    logic [CLW-1:0] col, col_n;
    logic           init_done_n;
    logic           frame_done_n;
    logic           en_n;
    logic           slot_start;
    logic           slot_rs;
    logic [7:0]     slot_byte;
    logic [AW-1:0]  rd_idx;
    logic [7:0]     mem [N];

    wire slot_last = (cnt == CW'(SLOT - 1));
    wire col_last  = (col == CLW'(COLS - 1));
    wire line_last = (line == LW'(LINES - 1));

    function automatic logic [7:0] init_cmd(input logic [1:0] s);
        case (s)
            2'd0:    return FUNC_SET;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // DDRAM start address of each display line.
    function automatic logic [6:0] line_offset(input logic [LW-1:0] l);
        case (int'(l))
            0:       return 7'h00;
            1:       return 7'h40;
            2:       return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    assign lcd_rw = 1'b0;

    // -------------------------------------------------------------------------
    // Frame buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer is reset on purpose so the panel shows blanks after a
    // reset; this costs a flop per bit instead of a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= SPACE;
        end else if (wr_en && (int'(wr_addr) < N)) begin
            mem[wr_addr] <= wr_char;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_PWR_WAIT;
            cnt   <= '0;
            step  <= '0;
            line  <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            step  <= step_n;
            line  <= line_n;
            col   <= col_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        step_n      = step;
        line_n      = line;
        col_n       = col;
        init_done_n = init_done;

        case (state)
            S_PWR_WAIT: begin
                if (cnt == CW'(PWR_WAIT_CYC - 1)) begin
                    state_n = S_INIT;
                    cnt_n   = '0;
                    step_n  = '0;
                end
            end
            S_INIT: begin
                if (slot_last) begin
                    cnt_n = '0;
                    if (step == 2'd3) state_n = S_CLR_WAIT;
                    else              step_n  = step + 2'd1;
                end
            end
            S_CLR_WAIT: begin
                if (cnt == CW'(CLR_WAIT_CYC - 1)) begin
                    state_n     = S_SET_ADDR;
                    cnt_n       = '0;
                    line_n      = '0;
                    init_done_n = 1'b1;
                end
            end
            S_SET_ADDR: begin
                if (slot_last) begin
                    state_n = S_WRITE_CHAR;
                    cnt_n   = '0;
                    col_n   = '0;
                end
            end
            S_WRITE_CHAR: begin
                if (slot_last) begin
                    cnt_n = '0;
                    if (!col_last) begin
                        col_n = col + CLW'(1);
                    end else if (!line_last) begin
                        line_n  = line + LW'(1);
                        state_n = S_SET_ADDR;
                    end else begin
                        // Frame boundary: the only place refresh_en is sampled.
                        line_n  = '0;
                        state_n = refresh_en ? S_SET_ADDR : S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                cnt_n = '0;
                if (refresh_en) begin
                    state_n = S_SET_ADDR;
                    line_n  = '0;
                end
            end
            default: begin
                state_n = S_PWR_WAIT;
                cnt_n   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Slot outputs, derived from the next state so they can be registered
    // -------------------------------------------------------------------------
    assign rd_idx = AW'(line_n) * AW'(COLS) + AW'(col_n);

    always_comb begin
        slot_byte = lcd_data;
        slot_rs   = 1'b0;
        case (state_n)
            S_INIT:       slot_byte = init_cmd(step_n);
            S_SET_ADDR:   slot_byte = {1'b1, line_offset(line_n)};
            S_WRITE_CHAR: begin
                slot_byte = mem[rd_idx];
                slot_rs   = 1'b1;
            end
            default:      slot_byte = lcd_data;
        endcase
    end

    // cnt_n is zero in a slot state only on the first cycle of a new slot.
    wire in_slot_n = (state_n == S_INIT) || (state_n == S_SET_ADDR) ||
                     (state_n == S_WRITE_CHAR);
    assign slot_start   = in_slot_n && (cnt_n == '0);
    assign en_n         = in_slot_n && (cnt_n < CW'(EN_HIGH_CYC));
    assign frame_done_n = (state_n == S_WRITE_CHAR) && (cnt_n == CW'(SLOT - 1)) &&
                          (col_n == CLW'(COLS - 1)) && (line_n == LW'(LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            lcd_en     <= en_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
            // Latched at slot start: a write to this character mid-slot only
            // shows up on the next frame.
            if (slot_start) begin
                lcd_data <= slot_byte;
                lcd_rs   <= slot_rs;
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_ctrl
//
// Bench for lcd_char_ctrl with a 4x2 panel and short timings. A reference
// model keeps the expected frame buffer and predicts the byte stream as a
// flat sequence: four init commands, then repeating frames of
// [set-address, COLS characters] per line. A per-cycle monitor checks slot
// timing, data/rs hold, init_done and frame_done against that model.
// -----------------------------------------------------------------------------
module tb_lcd_char_ctrl;

    localparam int COLS    = 4;
    localparam int LINES   = 2;
    localparam int EN_HIGH = 3;
    localparam int EN_LOW  = 2;
    localparam int PWR     = 20;
    localparam int CLR     = 10;
    localparam int N       = COLS * LINES;
    localparam int AW      = $clog2(N);
    localparam int PER     = LINES * (COLS + 1);
    localparam int SLOT    = EN_HIGH + EN_LOW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_char = 8'h00;
    logic          refresh_en = 1'b1;
    logic          lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
    logic [7:0]    lcd_data;

    lcd_char_ctrl #(
        .COLS(COLS), .LINES(LINES), .EN_HIGH_CYC(EN_HIGH), .EN_LOW_CYC(EN_LOW),
        .PWR_WAIT_CYC(PWR), .CLR_WAIT_CYC(CLR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .refresh_en(refresh_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] model_buf [N];
    logic [7:0] prev_buf  [N];   // buffer as it was before the latest edge
    logic [7:0] init_seq  [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    logic [7:0] line_off  [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    task automatic model_update();
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                model_buf[i] = 8'h20;
                prev_buf[i]  = 8'h20;
            end
        end else begin
            prev_buf = model_buf;
            if (wr_en && (int'(wr_addr) < N)) model_buf[wr_addr] = wr_char;
        end
    endtask

    // ---------------- monitor state ----------------
    int         slot_n, sc, low_run, cur_k, fd_count;
    logic       prev_en, last_final, idle_pending, rise_now;
    logic [7:0] exp_b;
    logic       exp_rs;
    logic [7:0] frame_bytes [PER];

    task automatic monitor_step();
        rise_now = 1'b0;
        if (!rst_n) begin
            slot_n = 0; sc = 99; low_run = 0; cur_k = -1;
            prev_en = 1'b0; last_final = 1'b0; idle_pending = 1'b0;
            exp_b = 8'h00; exp_rs = 1'b0;
            check("rst_en", lcd_en, 0);
            check("rst_data", lcd_data, 0);
            check("rst_init_done", init_done, 0);
            check("rst_frame_done", frame_done, 0);
            return;
        end
        if (lcd_en && !prev_en) begin
            rise_now = 1'b1;
            if (slot_n == 0)       check("pwr_gap", low_run, PWR);
            else if (slot_n == 4)  check("clr_gap", low_run, EN_LOW + CLR);
            else if (!idle_pending) check("slot_gap", low_run, EN_LOW);
            idle_pending = 1'b0;
            check("init_done_at_slot", init_done, (slot_n >= 4));
            if (slot_n < 4) begin
                exp_b = init_seq[slot_n]; exp_rs = 1'b0; cur_k = -1; last_final = 1'b0;
            end else begin
                int k, ln, pos;
                k   = (slot_n - 4) % PER;
                ln  = k / (COLS + 1);
                pos = k % (COLS + 1);
                exp_b  = (pos == 0) ? (8'h80 | line_off[ln]) : prev_buf[ln * COLS + pos - 1];
                exp_rs = (pos != 0);
                cur_k  = k;
                last_final = (k == PER - 1);
                frame_bytes[k] = lcd_data;
            end
            sc = 0;
            slot_n++;
        end else if (sc < 99) begin
            sc++;
        end
        if (!lcd_en && prev_en) check("en_high_len", sc, EN_HIGH);
        if (lcd_en) low_run = 0; else low_run++;
        check("data_hold", lcd_data, exp_b);
        check("rs_hold", lcd_rs, exp_rs);
        check("rw_zero", lcd_rw, 0);
        check("frame_done", frame_done, (last_final && sc == SLOT - 1));
        if (frame_done) fd_count++;
        if (last_final && sc == SLOT - 1) idle_pending = !refresh_en;
        prev_en = lcd_en;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        monitor_step();
    endtask

    // Release just after a rising edge so the first wait cycle is a full one.
    task automatic tick_release();
        @(posedge clk);
        model_update();
        #1 rst_n = 1'b1;
        @(negedge clk);
        monitor_step();
    endtask

    task automatic wr(input int addr, input logic [7:0] ch);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_char = ch;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frame(input int bound);
        int n = 0;
        do begin tick(); n++; end while (!frame_done && n < bound);
        if (!frame_done) check("frame_timeout", 0, 1);
    endtask

    task automatic wait_rise(input int bound);
        int n = 0;
        do begin tick(); n++; end while (!rise_now && n < bound);
        if (!rise_now) check("rise_timeout", 0, 1);
    endtask

    task automatic wait_slot(input int k, input int bound);
        int n = 0;
        do begin tick(); n++; end while (!(rise_now && cur_k == k) && n < bound);
        if (!(rise_now && cur_k == k)) check("slot_timeout", 0, 1);
    endtask

    task automatic check_frame_spaces(input string tag);
        for (int k = 0; k < PER; k++)
            check(tag, frame_bytes[k],
                  (k % (COLS + 1) != 0) ? 8'h20 : (8'h80 | line_off[k / (COLS + 1)]));
    endtask

    logic [7:0] msg [N] = '{"H", "R", ":", "7", "B", "P", " ", " "};

    initial begin
        int f0, highs;
        fd_count = 0;

        // Power-on init and an empty frame.
        repeat (3) tick();
        tick_release();
        check("init_done_pwr", init_done, 0);
        wait_frame(300);
        check("first_frame_count", fd_count, 1);
        check_frame_spaces("blank_frame");
        wait_frame(100);
        check("second_frame_count", fd_count, 2);

        // Random writes while refreshing.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom_range(N - 1));
                wr_char = 8'($urandom_range(126, 32));
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        wait_frame(100);
        wait_frame(100);
        for (int i = 0; i < N; i++)
            check("rand_frame", frame_bytes[(i / COLS) * (COLS + 1) + 1 + (i % COLS)], model_buf[i]);

        // Reset in the middle of an enable-high phase.
        wait_rise(100);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en", lcd_en, 0);
        check("midrst_data", lcd_data, 8'h00);
        check("midrst_init_done", init_done, 0);
        repeat (2) tick();
        tick_release();
        wait_frame(300);
        check_frame_spaces("post_reset_blank");

        // Writes before init completes.
        rst_n = 1'b0;
        repeat (2) tick();
        tick_release();
        for (int i = 0; i < 6; i++) wr(i, msg[i]);
        check("writes_before_init", init_done, 0);
        wait_frame(300);
        for (int i = 0; i < N; i++)
            check("msg_frame", frame_bytes[(i / COLS) * (COLS + 1) + 1 + (i % COLS)], msg[i]);

        // Write to the character currently on the bus.
        wait_slot(2, 100);
        wr(1, "X");
        wait_frame(100);
        check("midslot_old", frame_bytes[2], 8'h52);
        wait_frame(100);
        check("midslot_new", frame_bytes[2], 8'h58);

        // Drop refresh_en mid line 0: frame completes, then idle.
        wait_slot(2, 100);
        refresh_en = 1'b0;
        f0 = fd_count;
        wait_frame(100);
        highs = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (lcd_en) highs++;
        end
        check("idle_en_highs", highs, 0);
        check("idle_frame_pulses", fd_count - f0, 1);
        check("idle_last_line1", frame_bytes[PER - 1], 8'h20);
        refresh_en = 1'b1;
        wait_rise(20);
        check("resume_addr", lcd_data, 8'h80);
        check("resume_rs", lcd_rs, 0);
        wait_frame(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
